// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: opcode constants, FSM state type and
// default widths. The iterative multiplier (and its BUSY state) exists only
// when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_OPWIDTH = 6;

  // Opcodes are compared against the zero-extended op field. Each op has two
  // encodings, except SUB and MUL.
  localparam logic [31:0] OP_ADD0  = 32'h04, OP_ADD1  = 32'h0D;
  localparam logic [31:0] OP_SLT0  = 32'h05, OP_SLT1  = 32'h10;
  localparam logic [31:0] OP_SLTU0 = 32'h06, OP_SLTU1 = 32'h11;
  localparam logic [31:0] OP_XOR0  = 32'h07, OP_XOR1  = 32'h12;
  localparam logic [31:0] OP_OR0   = 32'h08, OP_OR1   = 32'h15;
  localparam logic [31:0] OP_AND0  = 32'h09, OP_AND1  = 32'h16;
  localparam logic [31:0] OP_SLL0  = 32'h0A, OP_SLL1  = 32'h0F;
  localparam logic [31:0] OP_SRL0  = 32'h0B, OP_SRL1  = 32'h13;
  localparam logic [31:0] OP_SRA0  = 32'h0C, OP_SRA1  = 32'h14;
  localparam logic [31:0] OP_SUB   = 32'h0E;
  localparam logic [31:0] OP_MUL   = 32'h17;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bus of alu_pipe. master = requester/consumer side,
// slave = the ALU.
interface alu_pipe_if import alu_pkg::*; #(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OPWIDTH = ALU_OPWIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [OPWIDTH-1:0] op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               out_zero;
  logic               out_err;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, out_zero, out_err
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, out_zero, out_err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is asserted during the last busy cycle with product already holding
// the final (low WIDTH bits) result, so the caller can register it that edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  // Partial sum including the current multiplier bit.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  // Load operands on start, then consume one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered result. Single-cycle ops have
// latency 1 and throughput 1. Define ALU_PIPE_MUL_EN to add the iterative
// multiplier (opcode 17, WIDTH+1 cycle latency); otherwise 17 is invalid.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OPWIDTH = ALU_OPWIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt, acc_tgt;
  logic             rdy, accept, is_mul, load_alu;
  logic [31:0]      opx;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] out_q;
  logic             zero_q, err_q;

  assign opx = 32'(bus.op);
  assign sh  = bus.in2[SHW-1:0];

  // Accepting in IDLE, or in DONE while the current result is being taken.
  assign rdy    = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_MUL_EN
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign is_mul  = (opx == OP_MUL);
  assign acc_tgt = is_mul ? BUSY : DONE;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.in1),
    .b       (bus.in2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul  = 1'b0;
  assign acc_tgt = DONE;
`endif

  assign load_alu = accept && !is_mul;

  // Single-cycle function block; unknown opcodes yield 0 with err set.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opx)
      OP_ADD0, OP_ADD1:   alu_res = bus.in1 + bus.in2;
      OP_SUB:             alu_res = bus.in1 - bus.in2;
      OP_SLT0, OP_SLT1:   alu_res = WIDTH'($signed(bus.in1) < $signed(bus.in2));
      OP_SLTU0, OP_SLTU1: alu_res = WIDTH'(bus.in1 < bus.in2);
      OP_XOR0, OP_XOR1:   alu_res = bus.in1 ^ bus.in2;
      OP_OR0, OP_OR1:     alu_res = bus.in1 | bus.in2;
      OP_AND0, OP_AND1:   alu_res = bus.in1 & bus.in2;
      OP_SLL0, OP_SLL1:   alu_res = bus.in1 << sh;
      OP_SRL0, OP_SRL1:   alu_res = bus.in1 >> sh;
      OP_SRA0, OP_SRA1:   alu_res = $signed(bus.in1) >>> sh;
      default:            alu_err = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = acc_tgt;
`ifdef ALU_PIPE_MUL_EN
      BUSY: begin
        if (mul_done)       state_nxt = DONE;
        else if (!mul_busy) state_nxt = IDLE;
      end
`endif
      DONE: begin
        if (accept)             state_nxt = acc_tgt;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result register: loads only on accept or multiplier completion, so it
  // holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (load_alu) begin
      out_q  <= alu_res;
      zero_q <= (alu_res == '0);
      err_q  <= alu_err;
    end
`ifdef ALU_PIPE_MUL_EN
    else if (mul_done) begin
      out_q  <= mul_prod;
      zero_q <= (mul_prod == '0);
      err_q  <= 1'b0;
    end
`endif
  end

  assign bus.in_ready  = rst_n && rdy;
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed cases plus random traffic, checked
// every cycle against a transaction-level model (result + cycles remaining).
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_pipe_if #(.WIDTH(32), .OPWIDTH(6)) bus();
  alu_pipe #(.WIDTH(32), .OPWIDTH(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model: m_has = result waiting for consumer, m_wait = cycles until one.
  bit          m_has = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  bit          m_err = 1'b0;

  logic [5:0] vops [20] = '{6'h04, 6'h0D, 6'h05, 6'h10, 6'h06, 6'h11, 6'h07,
                            6'h12, 6'h08, 6'h15, 6'h09, 6'h16, 6'h0A, 6'h0F,
                            6'h0B, 6'h13, 6'h0C, 6'h14, 6'h0E, 6'h17};

  function automatic logic [32:0] ref_alu(input logic [5:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      6'h04, 6'h0D: r = a + b;
      6'h0E:        r = a - b;
      6'h05, 6'h10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h06, 6'h11: r = (a < b) ? 32'd1 : 32'd0;
      6'h07, 6'h12: r = a ^ b;
      6'h08, 6'h15: r = a | b;
      6'h09, 6'h16: r = a & b;
      6'h0A, 6'h0F: r = a << b[4:0];
      6'h0B, 6'h13: r = a >> b[4:0];
      6'h0C, 6'h14: r = $unsigned($signed(a) >>> b[4:0]);
`ifdef ALU_PIPE_MUL_EN
      6'h17:        r = a * b;
`endif
      default:      e = 1'b1;
    endcase
    return {e, r};
  endfunction

  function automatic bit is_mul_op(input logic [5:0] op);
`ifdef ALU_PIPE_MUL_EN
    return op == 6'h17;
`else
    return (op == 6'h3F) && (op == 6'h00);
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit ordy);
    bus.in_valid  = v;
    bus.op        = o;
    bus.in1       = a;
    bus.in2       = b;
    bus.out_ready = ordy;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // return 1 time unit after the edge so the caller can drive new inputs.
  task automatic cyc();
    bit          rdy, acc;
    logic [32:0] r;
    @(posedge clk);
    rdy = rst_n && ((!m_has && m_wait == 0) || (m_has && bus.out_ready));
    acc = bus.in_valid && rdy;
    if (!rst_n) begin
      m_has  = 1'b0;
      m_wait = 0;
    end else begin
      if (m_has && bus.out_ready) m_has = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_has = 1'b1;
      end
      if (acc) begin
        r     = ref_alu(bus.op, bus.in1, bus.in2);
        m_res = r[31:0];
        m_err = r[32];
        if (is_mul_op(bus.op)) m_wait = 32;
        else                   m_has  = 1'b1;
      end
    end
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready,
        rst_n && ((!m_has && m_wait == 0) || (m_has && bus.out_ready)));
    chk("out_valid", bus.out_valid, m_has);
    if (m_has) begin
      chk("out", bus.out, m_res);
      chk("out_zero", bus.out_zero, m_res == 32'd0);
      chk("out_err", bus.out_err, m_err);
    end
    if (!rst_n) begin
      chk("rst out", bus.out, 0);
      chk("rst out_zero", bus.out_zero, 0);
      chk("rst out_err", bus.out_err, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [5:0]  o;
    logic [31:0] a, b;

    drive(0, 6'h00, '0, '0, 1);
    repeat (3) cyc();
    chk("rst in_ready", bus.in_ready, 0);
    rst_n = 1'b1;

    // Pin the model with hand-computed values.
    chk("ref add wrap", ref_alu(6'h04, 32'hFFFFFFFF, 32'd1), 33'h0_00000000);
    chk("ref sub wrap", ref_alu(6'h0E, 32'd0, 32'd1), 33'h0_FFFFFFFF);
    chk("ref sra", ref_alu(6'h14, 32'h80000000, 32'd31), 33'h0_FFFFFFFF);
    chk("ref sll 5b", ref_alu(6'h0A, 32'd1, 32'h34), 33'h0_00100000);
    chk("ref slt", ref_alu(6'h10, 32'hFFFFFFFF, 32'd1), 33'h0_00000001);
    chk("ref sltu", ref_alu(6'h06, 32'hFFFFFFFF, 32'd1), 33'h0_00000000);
    chk("ref bad op", ref_alu(6'h00, 32'd7, 32'd9), 33'h1_00000000);

    // ADD wrap, latency 1.
    drive(1, 6'h04, 32'hFFFFFFFF, 32'd1, 1); cyc();
    chk("add valid", bus.out_valid, 1);
    chk("add out", bus.out, 32'h0);
    chk("add zero", bus.out_zero, 1);

    // Back-to-back single-cycle ops, one result per cycle.
    drive(1, 6'h0C, 32'h80000000, 32'd31, 1); cyc();
    chk("sra out", bus.out, 32'hFFFFFFFF);
    drive(1, 6'h0F, 32'd1, 32'h34, 1); cyc();
    chk("sll out", bus.out, 32'h00100000);
    drive(1, 6'h05, 32'hFFFFFFFF, 32'd1, 1); cyc();
    chk("slt out", bus.out, 32'd1);
    drive(1, 6'h11, 32'hFFFFFFFF, 32'd1, 1); cyc();
    chk("sltu out", bus.out, 32'd0);
    chk("sltu valid", bus.out_valid, 1);
    drive(0, 6'h00, '0, '0, 1); cyc();

    // Stall: result held, new requests refused.
    drive(1, 6'h07, 32'hF0F0F0F0, 32'hFFFFFFFF, 1); cyc();
    drive(1, 6'h04, 32'd5, 32'd5, 0);
    repeat (5) begin
      cyc();
      chk("stall out", bus.out, 32'h0F0F0F0F);
      chk("stall in_ready", bus.in_ready, 0);
    end
    drive(1, 6'h04, 32'd5, 32'd5, 1); cyc();
    chk("post-stall add", bus.out, 32'd10);
    drive(0, 6'h00, '0, '0, 1); cyc();

    // MUL.
    drive(1, 6'h17, 32'h10000, 32'h10001, 1); cyc();
    drive(0, 6'h04, 32'd3, 32'd4, 1);
`ifdef ALU_PIPE_MUL_EN
    lat = 1;
    while (!bus.out_valid && lat < 40) begin cyc(); lat++; end
    chk("mul latency", lat, 33);
    chk("mul out", bus.out, 32'h00010000);
`else
    lat = 1;
    chk("mul-off valid", bus.out_valid, 1);
    chk("mul-off err", bus.out_err, 1);
    chk("mul-off out", bus.out, 32'd0);
`endif
    cyc();

    // Reset in the middle of a MUL.
    drive(1, 6'h17, 32'h10000, 32'h10001, 1); cyc();
    drive(0, 6'h00, '0, '0, 1);
    repeat (10) cyc();
    rst_n  = 1'b0;
    m_has  = 1'b0;
    m_wait = 0;
    #1;
    chk("rst mid out_valid", bus.out_valid, 0);
    chk("rst mid in_ready", bus.in_ready, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (40) cyc();
    drive(1, 6'h04, 32'd2, 32'd3, 1); cyc();
    chk("post-rst add", bus.out, 32'd5);
    drive(0, 6'h00, '0, '0, 1); cyc();

    // Random traffic.
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
      else                           o = vops[$urandom_range(0, 19)];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      drive($urandom_range(0, 9) < 7, o, a, b, $urandom_range(0, 3) != 0);
      cyc();
    end

    drive(0, 6'h00, '0, '0, 1);
    repeat (40) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>=8, power of two).
REQ-002 Parameter OPWIDTH, default 6, opcode width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 in1, in2  input  WIDTH each  operands.
REQ-008 op  input  OPWIDTH  opcode.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out  output  WIDTH  registered result.
REQ-012 out_zero  output  1  out == 0.
REQ-013 out_err  output  1  accepted opcode was invalid or disabled.

Function
REQ-014 Accept SHALL occur on a cycle with in_valid && in_ready; operands and op SHALL be captured, later input changes ignored.
REQ-015 Opcodes (hex): ADD 04/0D, SLT 05/10, SLTU 06/11, XOR 07/12, OR 08/15, AND 09/16, SLL 0A/0F, SRL 0B/13, SRA 0C/14, SUB 0E, MUL 17; both forms of each pair SHALL be identical.
REQ-016 Shift amount SHALL be in2[$clog2(WIDTH)-1:0]; SRA sign-fills; SLT signed, SLTU unsigned, result zero-extended 0/1.
REQ-017 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; MUL returns low WIDTH bits of unsigned product.
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE: in_ready=1; accept of non-MUL -> DONE with result registered, out_valid next cycle (latency 1).
REQ-020 IDLE: accept of MUL -> BUSY; iterative shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE (out_valid WIDTH+1 cycles after accept).
REQ-021 BUSY: in_ready=0, out_valid=0.
REQ-022 DONE: out_valid=1; out/out_zero/out_err held stable until out_ready=1.
REQ-023 DONE with out_ready=1: in_ready=1 same cycle; simultaneous accept loads next op (throughput 1 for non-MUL), else -> IDLE.
REQ-024 DONE with out_ready=0: in_ready=0.
REQ-025 Invalid opcode: out=0, out_err=1, out_zero=1, latency 1; no $display.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, out_valid=0, out=0, out_zero=0, out_err=0, multiplier state cleared, in_ready=0 while asserted.
REQ-027 Reset during BUSY or DONE SHALL discard the operation; no result emitted after release.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN defined: MUL (17) implemented per REQ-020.
REQ-029 ALU_PIPE_MUL_EN undefined: no multiplier logic or BUSY state; opcode 17 treated as invalid per REQ-025.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants, FSM state typedef, default WIDTH/OPWIDTH.
REQ-031 Sub-module alu_mul_iter SHALL implement the iterative multiplier (start, busy, done, product) and SHALL only be instantiated under ALU_PIPE_MUL_EN.
REQ-032 Single-cycle ops SHALL be one combinational function block feeding the out register.

Verification (WIDTH=32)
REQ-033 ADD 0xFFFFFFFF+1, out_ready=1 -> out=0, out_zero=1, out_valid 1 cycle after accept.
REQ-034 SRA 0x80000000 by in2=31 -> 0xFFFFFFFF; SLL 1 by 20 -> 0x00100000 (shift uses 5 bits).
REQ-035 SLT 0xFFFFFFFF<1 -> 1; SLTU same operands -> 0; back-to-back with out_ready=1 -> one result per cycle.
REQ-036 out_ready=0 for 5 cycles after XOR 0xF0F0F0F0^0xFFFFFFFF -> out=0x0F0F0F0F held, in_ready=0, new in_valid ignored.
REQ-037 MUL 0x10000*0x10001 with MUL_EN -> out=0x00010000 after 33 cycles; without MUL_EN -> out_err=1, out=0, latency 1.
REQ-038 rst_n low 10 cycles into MUL -> out_valid=0 immediately, IDLE after release, next ADD 2+3 -> 5.
